// File: rtl/non_overlap_1010_mealy_pkg.sv
// Shared definitions for the 1-0-1-0 serial pattern detector.
// Provides the prefix-tracking state encoding and the target pattern.
package non_overlap_1010_mealy_pkg;

   typedef enum logic [1:0] {
      S0 = 2'b00,  // idle, no prefix matched
      S1 = 2'b01,  // "1" matched
      S2 = 2'b10,  // "10" matched
      S3 = 2'b11   // "101" matched
   } state_e;

   // The oldest bit is the MSB.
   localparam logic [3:0] PATTERN = 4'b1010;

endpackage : non_overlap_1010_mealy_pkg

// File: rtl/non_overlap_1010_mealy_if.sv
// Serial bit-stream port bundle for the 1010 detector.
// The master supplies the data bit, and the slave (the detector) returns the detect flag.
interface non_overlap_1010_mealy_if;

   logic in;
   logic out;

   modport master (output in, input out);
   modport slave  (input in, output out);

endinterface : non_overlap_1010_mealy_if

// File: rtl/non_overlap_1010_mealy.sv
// Non-overlapping Mealy detector for the serial sequence 1-0-1-0.
// The detect flag is combinational and is high in the same cycle that the final '0' is presented.
module non_overlap_1010_mealy
   import non_overlap_1010_mealy_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   non_overlap_1010_mealy_if.slave  bus
);

   state_e state_q;
   state_e state_d;
   logic   match_d;

   // NOTE: sequential state uses non-blocking (<=) so that all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S0;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output of this block gets a default first, so that no path leaves a value unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      match_d = 1'b0;
      case (state_q)
         S0: state_d = bus.in ? S1 : S0;
         S1: state_d = bus.in ? S1 : S2;
         S2: state_d = bus.in ? S3 : S0;
         S3: begin
            // After a match, restart from idle so the matched bits are not reused.
            if (bus.in) begin
               state_d = S1;
            end else begin
               state_d = S0;
               match_d = 1'b1;
            end
         end
         default: state_d = S0;
      endcase
   end

   assign bus.out = match_d & ~rst;

endmodule : non_overlap_1010_mealy

// File: tb/tb_non_overlap_1010_mealy.sv
// Self-checking bench for non_overlap_1010_mealy.
// It uses directed sequences with hand-derived expected pulses, plus a random stream compared against a sliding-window reference.
module tb_non_overlap_1010_mealy;
   import non_overlap_1010_mealy_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   non_overlap_1010_mealy_if bus ();

   non_overlap_1010_mealy dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // The reference model tracks the bits seen since the last restart, meaning reset or a match.
   int         ref_cnt;
   logic [2:0] ref_win;

   function automatic logic ref_out(input logic r, input logic b);
      return !r && (ref_cnt >= 3) && ({ref_win, b} == PATTERN);
   endfunction

   task automatic ref_step(input logic r, input logic b);
      if (r || ref_out(r, b)) begin
         ref_cnt = 0;
         ref_win = 3'b000;
      end else begin
         ref_cnt++;
         ref_win = {ref_win[1:0], b};
      end
   endtask

   // Every task is entered and left at 1 time unit after a rising edge.
   task automatic do_reset();
      rst    = 1'b1;
      bus.in = 1'b0;
      @(posedge clk); #1;
      rst    = 1'b0;
   endtask

   task automatic drive_seq(input logic [15:0] bits, input logic [15:0] exp, input int n,
                            input string tag, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         bus.in = bits[n-1-i];
         #2;
         n_checks++;
         if (bus.out !== exp[n-1-i])
            $display("FAIL %s bit%0d: out=%b expected=%b", tag, i+1, bus.out, exp[n-1-i]);
         else
            n_pass++;
         if (bus.out === 1'b1) pulses++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      int pulses;
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         bus.in = 1'b1;
         #2;
         n_checks++;
         if (bus.out !== 1'b0) $display("FAIL reset_hold_in1 c%0d: out=%b expected=0", c, bus.out);
         else n_pass++;
         bus.in = 1'b0;
         #2;
         n_checks++;
         if (bus.out !== 1'b0) $display("FAIL reset_hold_in0 c%0d: out=%b expected=0", c, bus.out);
         else n_pass++;
         @(posedge clk); #1;
      end
      rst = 1'b0;
      drive_seq(16'b0000, 16'b0000, 4, "reset_idle_zeros", pulses);
   endtask

   task automatic test_alternating();
      int pulses;
      do_reset();
      drive_seq(16'b1010101010, 16'b0001000100, 10, "alternating", pulses);
      n_checks++;
      if (pulses !== 2) $display("FAIL alternating_pulse_count: got=%0d expected=2", pulses);
      else n_pass++;
   endtask

   task automatic test_restart_1011();
      int pulses;
      do_reset();
      drive_seq(16'b1011010, 16'b0000001, 7, "restart_1011", pulses);
   endtask

   task automatic test_prefix();
      int pulses;
      do_reset();
      drive_seq(16'b111010, 16'b000001, 6, "prefix_111010", pulses);
      do_reset();
      drive_seq(16'b1001010, 16'b0000001, 7, "prefix_1001010", pulses);
   endtask

   task automatic test_reset_mid_pattern();
      int pulses;
      do_reset();
      drive_seq(16'b101, 16'b000, 3, "midrst_prefix", pulses);
      // The state is "101" and in=0, but rst must still force out low.
      rst    = 1'b1;
      bus.in = 1'b0;
      #2;
      n_checks++;
      if (bus.out !== 1'b0) $display("FAIL midrst_forced_low: out=%b expected=0", bus.out);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      drive_seq(16'b0, 16'b0, 1, "midrst_discard", pulses);
      drive_seq(16'b1010, 16'b0001, 4, "midrst_rematch", pulses);
   endtask

   task automatic test_combinational();
      int pulses;
      do_reset();
      drive_seq(16'b101, 16'b000, 3, "comb_prefix", pulses);
      for (int k = 0; k < 3; k++) begin
         bus.in = k[0];
         #1;
         n_checks++;
         if (bus.out !== ~k[0]) $display("FAIL comb_follow k%0d: out=%b expected=%b", k, bus.out, ~k[0]);
         else n_pass++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic r, b, exp;
      do_reset();
      ref_cnt = 0;
      ref_win = 3'b000;
      for (int i = 0; i < 600; i++) begin
         r      = ($urandom_range(0, 49) == 0);
         b      = 1'($urandom_range(0, 1));
         rst    = r;
         bus.in = b;
         #2;
         exp = ref_out(r, b);
         n_checks++;
         if (bus.out !== exp) $display("FAIL random i%0d rst=%b in=%b: out=%b expected=%b", i, r, b, bus.out, exp);
         else n_pass++;
         ref_step(r, b);
         @(posedge clk); #1;
      end
      rst = 1'b0;
   endtask

   initial begin
      bus.in = 1'b0;
      #1;
      test_reset();
      test_alternating();
      test_restart_1011();
      test_prefix();
      test_reset_mid_pattern();
      test_combinational();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_non_overlap_1010_mealy

// File: doc/non_overlap_1010_mealy.md
Name: non_overlap_1010_mealy

Overview:
Serial bit-stream pattern detector for the sequence 1-0-1-0, sampled one bit per clock.
- Mealy FSM: the detect output depends on current state and current input, so the detect flag appears in the same cycle the final '0' is presented.
- Detection is non-overlapping. After a match the FSM restarts from idle, and no bits of the matched pattern are reused.
- Used as a leaf control block wherever a framing/marker pattern must be flagged on a 1-bit serial input.

Parameters:
- S0, 2'b00: state encoding, idle (no prefix matched).
- S1, 2'b01: state encoding, "1" matched.
- S2, 2'b10: state encoding, "10" matched.
- S3, 2'b11: state encoding, "101" matched.
- These are fixed local constants, not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in   input  1  serial data bit, sampled at each rising clk edge.
- out  output 1  detect flag, combinational (Mealy). High while state==S3 and in==0.

Behaviour:
- Reset:
  - Synchronous, active-high: rst=1 at a rising edge forces state to S0.
  - While rst=1, out is forced to 0 regardless of state or in.
  - rst has priority over any transition. Asserting rst mid-pattern discards the partial match.
- State register: 2 bits, updates only on the rising edge of clk. Next-state logic and output logic are purely combinational.
- Transitions (in=0 / in=1):
  - S0: 0 -> S0; 1 -> S1.
  - S1: 0 -> S2; 1 -> S1 (the newest '1' is a valid prefix).
  - S2: 0 -> S0; 1 -> S3.
  - S3: 0 -> S0 with out=1 (match; non-overlap restart); 1 -> S1 (the "1011" tail '1' becomes a new prefix).
- Output:
  - out = (state==S3) && (in==0) && !rst.
  - out is 0 in every other state/input combination.
- Latency: zero cycles from the final '0' to out=1. out is valid in the same cycle, before the edge that consumes the bit.
- out is a single-cycle pulse per match. Two matches can never occur in consecutive cycles (minimum 4 cycles between pulses).
- Non-overlap consequence:
  - Stream 1010101010 yields exactly 2 pulses, on bits 4 and 8.
  - An overlapping detector would yield 4 pulses.
- The 2-bit encoding is fully used, so there are no illegal states and no recovery logic is needed.
- out is glitch-sensitive to in. Downstream logic must sample out on clk.

Decomposition:
- Shared package: 2-bit state enum (S0..S3 with the encodings above) and the pattern constant 4'b1010 for bench reference models.
- No sub-module. A single module holds the state register, next-state logic and output logic.

Test Plan:
- Reset: hold rst=1 for 2 edges with in toggling -> state S0 and out=0 throughout. Release rst, hold in=0 for 4 edges -> out stays 0.
- Alternating stream: after reset, drive in = 1,0,1,0,1,0,1,0,1,0 (one bit per clock) -> out=1 only during bits 4 and 8, 0 elsewhere. Exactly 2 pulses.
- Restart after 1011: drive 1,0,1,1,0,1,0 -> out=0 during bit 4 ('1'). out=1 during bit 7, because the bit-4 '1' restarts the match as S1.
- Prefix robustness: drive 1,1,1,0,1,0 -> out=1 only during bit 6. Drive 1,0,0,1,0,1,0 -> out=1 only during bit 7, because "100" returns to S0.
- Reset mid-pattern: drive 1,0,1, assert rst for one edge, then drive 0 -> out=0 (partial match discarded). A following 1,0,1,0 -> out=1 on its 4th bit.
- Combinational check: sit in S3 and toggle in between clock edges -> out follows in (in=0 gives out=1, in=1 gives out=0) with no clock delay.
